// File: rtl/spdif_tx_if.sv
// rtl/spdif_tx_if.sv - sample fetch, channel-status and line signals of spdif_tx
interface spdif_tx_if;
    logic [23:0]  data_i;
    logic [1:0]   ack_i;
    logic [191:0] cdata_i;
    logic [1:0]   pop_o;
    logic         signal_o;
    logic         underrun_o;

    modport master (
        input  data_i, ack_i, cdata_i,
        output pop_o, signal_o, underrun_o
    );

    modport slave (
        output data_i, ack_i, cdata_i,
        input  pop_o, signal_o, underrun_o
    );
endinterface

// File: rtl/spdif_tx.sv
// rtl/spdif_tx.sv - S/PDIF (IEC 60958) biphase-mark transmitter
module spdif_tx #(
    parameter int HALFBIT_DIV = 4
) (
    input logic        clk,
    input logic        rst,
    spdif_tx_if.master bus
);
    localparam int PW = (HALFBIT_DIV > 1) ? $clog2(HALFBIT_DIV) : 1;
    localparam logic [PW-1:0] PMAX  = PW'(HALFBIT_DIV - 1);
    localparam logic [PW-1:0] PMAX1 = PW'((HALFBIT_DIV > 1) ? HALFBIT_DIV - 2 : 0);
    localparam logic [7:0] PRE_Z = 8'b11101000;
    localparam logic [7:0] PRE_X = 8'b11100010;
    localparam logic [7:0] PRE_Y = 8'b11100100;

    typedef enum logic [1:0] {S_IDLE, S_LEAD, S_RUN} state_t;

    state_t         state;
    logic [PW-1:0]  presc;
    logic           phase;
    logic [4:0]     slot;
    logic           chan;
    logic [7:0]     frame;
    logic [23:0]    hold;
    logic           have;
    logic           req;
    logic [31:0]    sf;
    logic [7:0]     pat;
    logic           ref_lvl;
    logic           line;
    logic [191:0]   cstat;

    logic [5:0]     hc;
    logic [5:0]     hc_n;
    logic           half_end;
    logic           last_cyc;
    logic           pre_last;
    logic           nxt_chan;
    logic [7:0]     nxt_frame;
    logic [7:0]     nxt_pat;
    logic           nxt_c;
    logic [23:0]    audio;
    logic [31:0]    nxt_sf;
    logic           nxt_lvl;

    assign bus.signal_o = line;

    always_comb begin
        hc       = {slot, phase};
        hc_n     = hc + 6'd1;
        half_end = (presc == PMAX);
        last_cyc = half_end && (hc == 6'd63);
        if (HALFBIT_DIV == 1)
            pre_last = (hc == 6'd62);
        else
            pre_last = (hc == 6'd63) && (presc == PMAX1);

        // What the subframe loaded at the end of this one will carry
        nxt_chan = (state == S_LEAD) ? 1'b0 : ~chan;
        if (state == S_LEAD)
            nxt_frame = 8'd0;
        else if (chan)
            nxt_frame = (frame == 8'd191) ? 8'd0 : frame + 8'd1;
        else
            nxt_frame = frame;
        if (nxt_chan)
            nxt_pat = PRE_Y;
        else if (nxt_frame == 8'd0)
            nxt_pat = PRE_Z;
        else
            nxt_pat = PRE_X;
        nxt_c  = (!nxt_chan && nxt_frame == 8'd0) ? bus.cdata_i[0] : cstat[nxt_frame];
        audio  = have ? hold : 24'd0;
        nxt_sf = {^{audio, ~have, nxt_c}, nxt_c, 1'b0, ~have, audio, 4'b0000};

        // Preamble halves are absolute levels; data slots toggle at start, and mid-slot on a 1
        if (hc_n < 6'd8)
            nxt_lvl = pat[3'd7 - hc_n[2:0]] ^ ref_lvl;
        else if (hc_n[0])
            nxt_lvl = line ^ sf[hc_n[5:1]];
        else
            nxt_lvl = ~line;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= S_IDLE;
            presc          <= '0;
            phase          <= 1'b0;
            slot           <= 5'd0;
            chan           <= 1'b0;
            frame          <= 8'd0;
            hold           <= 24'd0;
            have           <= 1'b0;
            req            <= 1'b0;
            sf             <= 32'd0;
            pat            <= 8'd0;
            ref_lvl        <= 1'b0;
            line           <= 1'b0;
            bus.pop_o      <= 2'b00;
            bus.underrun_o <= 1'b0;
        end else begin
            bus.pop_o      <= 2'b00;
            bus.underrun_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    state     <= S_LEAD;
                    presc     <= '0;
                    phase     <= 1'b0;
                    slot      <= 5'd0;
                    have      <= 1'b0;
                    req       <= 1'b0;
                    bus.pop_o <= 2'b01;
                end
                default: begin
                    if (half_end) begin
                        presc         <= '0;
                        {slot, phase} <= hc_n;
                    end else begin
                        presc <= presc + PW'(1);
                    end
                    // Flag one cycle early so the pulse lines up with the load cycle
                    if (state == S_RUN && pre_last && !(have || bus.ack_i[req]))
                        bus.underrun_o <= 1'b1;
                    if (last_cyc) begin
                        state     <= S_RUN;
                        chan      <= nxt_chan;
                        frame     <= nxt_frame;
                        pat       <= nxt_pat;
                        sf        <= nxt_sf;
                        ref_lvl   <= line;
                        line      <= nxt_pat[7] ^ line;
                        have      <= 1'b0;
                        req       <= ~nxt_chan;
                        bus.pop_o <= nxt_chan ? 2'b01 : 2'b10;
                        if (!nxt_chan && nxt_frame == 8'd0)
                            cstat <= bus.cdata_i;
                    end else begin
                        if (!have && bus.ack_i[req]) begin
                            hold <= bus.data_i;
                            have <= 1'b1;
                        end
                        if (half_end && state == S_RUN)
                            line <= nxt_lvl;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spdif_tx.sv
// tb/tb_spdif_tx.sv - directed checks of spdif_tx coding, fetch, underrun and reset
module tb_spdif_tx;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst4;
    logic rst1;
    spdif_tx_if bus4 ();
    spdif_tx_if bus1 ();

    spdif_tx #(.HALFBIT_DIV(4)) dut4 (.clk(clk), .rst(rst4), .bus(bus4.master));
    spdif_tx #(.HALFBIT_DIV(1)) dut1 (.clk(clk), .rst(rst1), .bus(bus1.master));

    localparam logic [7:0] PZ = 8'b11101000;
    localparam logic [7:0] PX = 8'b11100010;
    localparam logic [7:0] PY = 8'b11100100;

    int n_tests = 0;
    int n_fail  = 0;

    // mode 0: ack after dly cycles, 1: never ack, 2: wrong-channel then two acks
    typedef struct packed {
        logic [23:0] val;
        logic [15:0] dly;
        logic [1:0]  mode;
    } ack_t;

    typedef struct {
        logic [23:0] lval; logic [15:0] ldly; logic [1:0] lmode;
        logic [23:0] rval; logic [15:0] rdly; logic [1:0] rmode;
        logic [23:0] exp_l; logic exp_vl;
        logic [23:0] exp_r; logic exp_vr;
        logic        exp_c;
    } vec_t;

    ack_t lq[$];
    ack_t rq[$];
    vec_t vt[6];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic grab(input bit sel, output logic [63:0] h, output logic [1:0] pop0,
                        output logic url, output logic bad);
        int div;
        logic ln, ur;
        logic [1:0] pp;
        div = sel ? 1 : 4;
        h = '0; pop0 = 2'b00; url = 1'b0; bad = 1'b0;
        for (int i = 0; i < 64; i++) begin
            for (int k = 0; k < div; k++) begin
                @(negedge clk);
                ln = sel ? bus1.signal_o : bus4.signal_o;
                pp = sel ? bus1.pop_o : bus4.pop_o;
                ur = sel ? bus1.underrun_o : bus4.underrun_o;
                if (k == 0) h[i] = ln;
                else if (ln != h[i]) bad = 1'b1;
                if (i == 0 && k == 0) pop0 = pp;
                else if (pp != 2'b00) bad = 1'b1;
                if (i == 63 && k == div - 1) url = ur;
                else if (ur) bad = 1'b1;
            end
        end
    endtask

    task automatic decode(input logic [63:0] h, input logic rf, output logic [7:0] pre,
                          output logic [27:0] bits, output logic viol);
        viol = 1'b0;
        for (int i = 0; i < 8; i++) pre[7-i] = h[i] ^ rf;
        for (int s = 4; s < 32; s++) begin
            bits[s-4] = h[2*s] ^ h[2*s+1];
            if (h[2*s] == h[2*s-1]) viol = 1'b1;
        end
    endtask

    initial begin : resp4
        ack_t cur;
        int wt;
        int step;
        bit pend;
        logic [1:0] side;
        wt = 0; step = 0; pend = 1'b0; side = 2'b00; cur = '0;
        bus4.ack_i = 2'b00;
        bus4.data_i = 24'd0;
        forever begin
            @(posedge clk); #2;
            bus4.ack_i = 2'b00;
            if (pend) begin
                wt--;
                if (wt == 0) begin
                    if (cur.mode == 2'd2) begin
                        step++;
                        case (step)
                            1: begin bus4.data_i = 24'h999999; bus4.ack_i = 2'b10; end
                            2: begin bus4.data_i = 24'hABCDEF; bus4.ack_i = 2'b01; end
                            default: begin bus4.data_i = 24'h123456; bus4.ack_i = 2'b01; end
                        endcase
                        if (step < 3) wt = 1; else pend = 1'b0;
                    end else begin
                        bus4.data_i = cur.val;
                        bus4.ack_i = side;
                        pend = 1'b0;
                    end
                end
            end
            if (rst4 && bus4.pop_o != 2'b00) begin
                pend = 1'b0;
                if (bus4.pop_o[0] && lq.size() > 0) begin
                    cur = lq.pop_front(); side = 2'b01; pend = (cur.mode != 2'd1);
                end else if (bus4.pop_o[1] && rq.size() > 0) begin
                    cur = rq.pop_front(); side = 2'b10; pend = (cur.mode != 2'd1);
                end
                wt = int'(cur.dly); step = 0;
            end
        end
    end

    initial begin : resp1
        logic [23:0] lcnt, rcnt;
        bit pend, side;
        lcnt = 24'd0; rcnt = 24'd0; pend = 1'b0; side = 1'b0;
        bus1.ack_i = 2'b00;
        bus1.data_i = 24'd0;
        forever begin
            @(posedge clk); #2;
            bus1.ack_i = 2'b00;
            if (!rst1) begin
                lcnt = 24'd0; rcnt = 24'd0; pend = 1'b0;
            end else begin
                if (pend) begin
                    if (!side) begin bus1.data_i = lcnt; lcnt++; bus1.ack_i = 2'b01; end
                    else begin bus1.data_i = ~rcnt; rcnt++; bus1.ack_i = 2'b10; end
                    pend = 1'b0;
                end
                if (bus1.pop_o != 2'b00) begin pend = 1'b1; side = bus1.pop_o[1]; end
            end
        end
    end

    initial begin : watchdog
        #1500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [63:0] h;
        logic [1:0]  pop0, ep;
        logic        url, bad, rf, viol, v, c, p, eur;
        logic [7:0]  pre, epre;
        logic [27:0] bits;
        logic [23:0] a;

        vt[0] = '{24'h000001, 16'd1,   2'd0, 24'h000001, 16'd1,   2'd0, 24'h000001, 1'b0, 24'h000001, 1'b0, 1'b0};
        vt[1] = '{24'h5A5A5A, 16'd5,   2'd0, 24'h000000, 16'd0,   2'd1, 24'h5A5A5A, 1'b0, 24'h000000, 1'b1, 1'b0};
        vt[2] = '{24'h000000, 16'd1,   2'd2, 24'h00F00F, 16'd2,   2'd0, 24'hABCDEF, 1'b0, 24'h00F00F, 1'b0, 1'b0};
        vt[3] = '{24'h800000, 16'd254, 2'd0, 24'h000007, 16'd100, 2'd0, 24'h800000, 1'b0, 24'h000007, 1'b0, 1'b0};
        vt[4] = '{24'h111111, 16'd255, 2'd0, 24'h654321, 16'd1,   2'd0, 24'h000000, 1'b1, 24'h654321, 1'b0, 1'b0};
        vt[5] = '{24'hFFFFFF, 16'd1,   2'd0, 24'h000000, 16'd3,   2'd0, 24'hFFFFFF, 1'b0, 24'h000000, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            lq.push_back('{vt[i].lval, vt[i].ldly, vt[i].lmode});
            rq.push_back('{vt[i].rval, vt[i].rdly, vt[i].rmode});
        end

        rst4 = 1'b0;
        rst1 = 1'b0;
        bus4.cdata_i = 192'h20;
        bus1.cdata_i = 192'h5;
        repeat (3) @(negedge clk);
        check("reset4_out", {bus4.signal_o, bus4.pop_o, bus4.underrun_o}, 0);
        check("reset1_out", {bus1.signal_o, bus1.pop_o, bus1.underrun_o}, 0);

        // HALFBIT_DIV=4: lead-in, then six frames driven from the vector table
        rst4 = 1'b1;
        grab(1'b0, h, pop0, url, bad);
        check("t1_lead_pop", pop0, 2'b01);
        check("t1_lead_line", h, 0);
        check("t1_lead_ur", url, 0);
        check("t1_lead_glitch", bad, 0);
        rf = 1'b0;
        for (int i = 0; i < 6; i++) begin
            for (int ch = 0; ch < 2; ch++) begin
                grab(1'b0, h, pop0, url, bad);
                if (i == 0 && ch == 0) begin
                    check("t1_z_head", h[9:0], 10'b0100010111);
                    check("t1_z_tail", h[63:56], 8'b01001100);
                end
                decode(h, rf, pre, bits, viol);
                rf = h[63];
                epre = (ch == 1) ? PY : ((i == 0) ? PZ : PX);
                a = (ch == 0) ? vt[i].exp_l : vt[i].exp_r;
                v = (ch == 0) ? vt[i].exp_vl : vt[i].exp_vr;
                c = vt[i].exp_c;
                p = ^{a, v, c};
                check("t4_subframe", {pre, bits, viol}, {epre, p, c, 1'b0, v, a, 1'b0});
                ep = (ch == 0) ? 2'b10 : 2'b01;
                if (ch == 0) eur = vt[i].exp_vr;
                else eur = (i < 5) ? vt[i+1].exp_vl : 1'b1;
                check("t4_pop", pop0, ep);
                check("t4_underrun", url, eur);
                check("t4_glitch", bad, 0);
            end
        end
        rst4 = 1'b0;

        // HALFBIT_DIV=1: ramp over 400 frames with channel status, then mid-subframe reset
        rst1 = 1'b1;
        grab(1'b1, h, pop0, url, bad);
        check("t2_lead", {pop0, url, bad, h}, {2'b01, 1'b0, 1'b0, 64'd0});
        rf = 1'b0;
        for (int f = 0; f < 400; f++) begin
            if (f == 100) bus1.cdata_i = 192'h2;
            for (int ch = 0; ch < 2; ch++) begin
                grab(1'b1, h, pop0, url, bad);
                decode(h, rf, pre, bits, viol);
                rf = h[63];
                a = (ch == 0) ? f[23:0] : ~f[23:0];
                c = (f < 192) ? (f == 0 || f == 2) : ((f % 192) == 1);
                epre = (ch == 1) ? PY : (((f % 192) == 0) ? PZ : PX);
                p = ^{a, c};
                check("t2_subframe", {pre, bits, viol}, {epre, p, c, 1'b0, 1'b0, a, 1'b0});
                ep = (ch == 0) ? 2'b10 : 2'b01;
                check("t2_flags", {pop0, url, bad}, {ep, 1'b0, 1'b0});
            end
        end

        repeat (31) @(negedge clk);
        rst1 = 1'b0;
        @(negedge clk);
        check("t6_reset_out", {bus1.signal_o, bus1.pop_o, bus1.underrun_o}, 0);
        rst1 = 1'b1;
        grab(1'b1, h, pop0, url, bad);
        check("t6_lead", {pop0, url, bad, h}, {2'b01, 1'b0, 1'b0, 64'd0});
        grab(1'b1, h, pop0, url, bad);
        decode(h, 1'b0, pre, bits, viol);
        check("t6_first", {pre, bits, viol}, {PZ, 1'b0, 1'b0, 1'b0, 1'b0, 24'd0, 1'b0});
        check("t6_flags", {pop0, url, bad}, {2'b10, 1'b0, 1'b0});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
